sd_fifo_tx_filler: RTL
======================

SD_FIFO_TX_FILLER -- requirements
Module: sd_fifo_tx_filler

Interface
REQ-001 SHALL have parameter ADR_INC, default 4: byte increment applied to wbm_adr_o per word fetched.
REQ-002 SHALL have parameter CNT_W, default 16: width of the word counter and of xfer_words.
REQ-003 clk  input  1  single clock for all logic; wishbone and FIFO write side both run on it.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  transfer enable; rising edge starts a transfer, low aborts it.
REQ-006 adr  input  32  byte start address of the source buffer, sampled at start.
REQ-007 xfer_words  input  CNT_W  number of 32-bit words to move, sampled at start.
REQ-008 wbm_adr_o  output  32  wishbone master address.
REQ-009 wbm_cyc_o / wbm_stb_o  output  1 each  wishbone cycle and strobe, always equal.
REQ-010 wbm_we_o  output  1  wishbone write enable, constant 0 (read-only master).
REQ-011 wbm_dat_i  input  32  wishbone read data; wbm_ack_i  input  1  wishbone acknowledge.
REQ-012 fifo_dat_o  output  32  word to the TX FIFO d port.
REQ-013 fifo_wr_o  output  1  TX FIFO write strobe, one cycle per word.
REQ-014 fifo_full_i  input  1  TX FIFO full flag.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when all xfer_words words are written.

Function
REQ-017 SHALL implement states IDLE, WAIT, READ, PUSH; all outputs registered.
REQ-018 SHALL register en as en_q; start = en & ~en_q, evaluated in IDLE only.
REQ-019 IDLE with start and xfer_words!=0: latch adr into wbm_adr_o, latch xfer_words, clear count, go to WAIT.
REQ-020 IDLE with start and xfer_words==0: pulse done next cycle, stay IDLE, no bus cycle.
REQ-021 WAIT: en low -> IDLE, no done; else fifo_full_i low -> READ with cyc/stb set high on the same edge; else stay.
REQ-022 READ: hold cyc/stb and wbm_adr_o stable until wbm_ack_i; en is ignored in READ so that no cycle is dropped mid-transfer.
REQ-023 READ with wbm_ack_i: on that edge capture wbm_dat_i into fifo_dat_o, drop cyc/stb, count += 1, wbm_adr_o += ADR_INC (32-bit wrap), set fifo_wr_o, go to PUSH.
REQ-024 PUSH: fifo_wr_o high exactly this one cycle; cleared on exit.
REQ-025 PUSH exit: count==latched xfer_words -> done pulse next cycle, IDLE; else en low -> IDLE, no done; else WAIT.
REQ-026 SHALL never raise fifo_wr_o while fifo_full_i is high. Guaranteed by the READ-entry check, because this block is the sole FIFO writer.
REQ-027 Throughput: one word per 3 cycles with zero-wait ack (WAIT, READ, PUSH); each ack wait state adds one cycle.
REQ-028 A new transfer SHALL require en low for at least one cycle after the previous start (edge detect).
REQ-029 count SHALL be CNT_W bits; xfer_words = 2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-030 While rst is high, the block SHALL: hold state at IDLE; drive wbm_cyc_o, wbm_stb_o, wbm_we_o, fifo_wr_o, busy and done to 0; drive wbm_adr_o, fifo_dat_o and count to 0; clear en_q to 0.
REQ-031 If rst is asserted mid-bus-cycle, cyc/stb SHALL drop asynchronously, and any late ack SHALL be ignored in IDLE.
REQ-032 If en is already high when rst releases, no start SHALL occur until en falls and rises again.

Verification
REQ-033 adr=0x1000, xfer_words=4, zero-wait ack, FIFO never full -> wbm_adr_o 0x1000,0x1004,0x1008,0x100C; four fifo_wr_o pulses 3 cycles apart carrying wbm_dat_i values in order; done pulses once; busy then 0.
REQ-034 fifo_full_i held high for 10 cycles during WAIT -> cyc stays 0 for those cycles; fetch resumes the cycle after full falls; no write occurs while full.
REQ-035 en dropped while in READ with ack delayed 5 cycles -> cyc is held until ack, that word is pushed, then IDLE; no done; count=1.
REQ-036 xfer_words=0 with en rising -> done pulse one cycle later; wbm_cyc_o never asserts.
REQ-037 rst pulsed during READ -> cyc/stb/fifo_wr_o go to 0 immediately; a subsequent ack causes no FIFO write; en held high causes no restart.
REQ-038 adr=0xFFFFFFFC, xfer_words=2 -> addresses 0xFFFFFFFC then 0x00000000; done asserted.

Source files
------------

// File: rtl/sd_fifo_tx_filler.sv
// sd_fifo_tx_filler: wishbone read master that copies xfer_words 32-bit
// words from a byte-addressed source buffer into the SD TX FIFO.
// One word per WAIT -> READ -> PUSH round; a word is only fetched when the
// FIFO has room, so a fetched word can always be written.
module sd_fifo_tx_filler #(
  parameter int ADR_INC = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      adr,
  input  logic [CNT_W-1:0] xfer_words,
  output logic [31:0]      wbm_adr_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic [31:0]      fifo_dat_o,
  output logic             fifo_wr_o,
  input  logic             fifo_full_i,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_PUSH} state_t;

  localparam logic [31:0]      ADR_STEP = 32'(ADR_INC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic             en_q;
  logic             armed_q;   // en has been seen low since reset
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] words_q;
  logic [31:0]      adr_q;
  logic [31:0]      dat_q;
  logic             cyc_q;
  logic             wr_q;
  logic             busy_q;
  logic             done_q;
  logic             start_d;

  // Rising edge of en; armed_q blocks a start when en is already high at reset release.
  assign start_d = en & ~en_q & armed_q;

  // Transfer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      words_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q    <= en;
      armed_q <= armed_q | ~en;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            if (xfer_words != '0) begin
              adr_q   <= adr;
              words_q <= xfer_words;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!en) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!fifo_full_i) begin
            cyc_q   <= 1'b1;
            state_q <= S_READ;
          end
        end
        // en is deliberately ignored here: a started bus cycle always completes.
        S_READ: begin
          if (wbm_ack_i) begin
            dat_q   <= wbm_dat_i;
            cyc_q   <= 1'b0;
            cnt_q   <= cnt_q + CNT_ONE;
            adr_q   <= adr_q + ADR_STEP;
            wr_q    <= 1'b1;
            state_q <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (cnt_q == words_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!en) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wbm_adr_o  = adr_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = 1'b0;
  assign fifo_dat_o = dat_q;
  assign fifo_wr_o  = wr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
